// File: rtl/md_pkg.sv
// Shared encodings, latency defaults and FSM states for the multiply/divide unit.
package md_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned MD_MULT_CYCLES   = 5;
    localparam int unsigned MD_DIV_CYCLES    = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_counter.sv
// Loadable down-counter that flags the final busy cycle (count == 1).
module md_counter
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Counts down to zero and parks there until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit with emulated multi-cycle latency and a busy flag.
// Optional HI/LO write trace is enabled by defining MD_UNIT_TRACE_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] PC,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    md_state_e         state, state_next;
    logic              load, commit, wr_hi, wr_lo, done, is_mult, div0;
    logic [CNT_W-1:0]  load_val;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        op_q;

    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [DATA_W-1:0]   dvd, dvs, dvs_safe, q_mag, r_mag;
    logic                is_sdiv, neg_q, neg_r;
    logic [DATA_W-1:0]   res_hi, res_lo;

    md_counter u_counter (
        .clk      (clk),
        .rst_n    (reset),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    assign is_mult  = (op == MD_MULT) || (op == MD_MULTU);
    assign load_val = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            load       = 1'b1;
                            state_next = BUSY;
                        end
                        MD_MTHI: wr_hi = 1'b1;
                        MD_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (done) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed division runs on magnitudes so INT_MIN / -1 wraps instead of trapping.
    always_comb begin
        prod_s   = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
        prod_u   = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
        is_sdiv  = (op_q == MD_DIV);
        dvd      = (is_sdiv && a_q[DATA_W-1]) ? DATA_W'(-a_q) : a_q;
        dvs      = (is_sdiv && b_q[DATA_W-1]) ? DATA_W'(-b_q) : b_q;
        dvs_safe = (dvs == '0) ? DATA_W'(1) : dvs;
        q_mag    = dvd / dvs_safe;
        r_mag    = dvd % dvs_safe;
        neg_q    = is_sdiv && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        neg_r    = is_sdiv && a_q[DATA_W-1];
        div0     = ((op_q == MD_DIV) || (op_q == MD_DIVU)) && (b_q == '0);
        case (op_q)
            MD_MULT: begin
                res_hi = prod_s[2*DATA_W-1:DATA_W];
                res_lo = prod_s[DATA_W-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*DATA_W-1:DATA_W];
                res_lo = prod_u[DATA_W-1:0];
            end
            default: begin
                res_hi = neg_r ? DATA_W'(-r_mag) : r_mag;
                res_lo = neg_q ? DATA_W'(-q_mag) : q_mag;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            busy <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            busy <= (state_next == BUSY);
            if (load) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
            end
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
            if (commit && !div0) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end

`ifdef MD_UNIT_TRACE_EN
    logic [DATA_W-1:0] pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    pc_q <= '0;
        else if (load) pc_q <= PC;
    end

    // Trace mirrors the HI/LO write enables above.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (wr_hi) $display("@%h: HI <= %h", PC, A);
            if (wr_lo) $display("@%h: LO <= %h", PC, A);
            if (commit && !div0) begin
                $display("@%h: HI <= %h", pc_q, res_hi);
                $display("@%h: LO <= %h", pc_q, res_lo);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO/busy, a monitor checks them.
module tb_md_unit;

    typedef struct {
        int          due;
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0, B = '0, PC = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int          edge_cnt = 0;
    int          run = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .PC    (PC),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    endfunction

    // Reference model: architectural effect of one accepted op issued at edge k.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input int k);
        exp_t        e;
        longint      p, sa, sbv;
        longint unsigned pu;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.len = 0;
        e.tag = $sformatf("op%0d", o);
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32]; e.lo = p[31:0]; e.len = 5;
            end
            3'd1: begin
                pu = {32'b0, a};
                pu = pu * {32'b0, b};
                e.hi = pu[63:32]; e.lo = pu[31:0]; e.len = 5;
            end
            3'd2: begin
                e.len = 10;
                if (b != 0) begin
                    sa = longint'($signed(a)); sbv = longint'($signed(b));
                    p = sa / sbv; e.lo = p[31:0];
                    p = sa % sbv; e.hi = p[31:0];
                end
            end
            3'd3: begin
                e.len = 10;
                if (b != 0) begin e.lo = a / b; e.hi = a % b; end
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        e.due = k + e.len;
        m_hi  = e.hi;
        m_lo  = e.lo;
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (busy) run++;
            while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                e = sb.pop_front();
                if (e.due != edge_cnt) check({e.tag, "_stale"}, 32'(edge_cnt), 32'(e.due));
                check({e.tag, "_busy"}, 32'(busy), 32'd0);
                check({e.tag, "_hi"}, HI, e.hi);
                check({e.tag, "_lo"}, LO, e.lo);
                if (e.len >= 0) check({e.tag, "_busy_len"}, 32'(run), 32'(e.len));
                run = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int due);
        exp_t e;
        start = 1'b1; op = o; A = a; B = b; PC = $urandom;
        e = model(o, a, b, edge_cnt + 1);
        due = e.due;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_until(input int due);
        while (edge_cnt < due) @(negedge clk);
    endtask

    task automatic push_quiet(input string tag, input int len);
        exp_t e;
        e.due = edge_cnt + 1; e.len = len; e.hi = m_hi; e.lo = m_lo; e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'd0;
            1:       v = 32'($urandom_range(1, 9));
            2:       v = -32'($urandom_range(1, 9));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int due, due2, k, j;
        logic [2:0] o;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        push_quiet("reset", -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases from the bring-up list.
        issue(3'd0, 32'd3, 32'hFFFF_FFFE, due);
        wait_until(due);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, due);
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        wait_until(due);
        issue(3'd4, 32'h1234_5678, 32'd0, due);
        wait_until(due);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, due);
        wait_until(due);
        issue(3'd3, 32'd7, 32'd0, due);
        wait_until(due);

        // Reset in the middle of a divide.
        issue(3'd2, 32'd100, 32'd7, due);
        k = due - 10;
        while (edge_cnt < k + 3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_hi", HI, 32'd0);
        check("rst_async_lo", LO, 32'd0);
        push_quiet("rst_mid", -1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        push_quiet("no_late_commit", 0);
        @(negedge clk);

        // Start held across the commit edge: only the following edge accepts it.
        issue(3'd0, 32'd7, 32'd9, due);
        while (edge_cnt < due - 1) @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'hFFFF_FFF0; B = 32'd3;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        begin
            exp_t e;
            e = model(3'd0, 32'hFFFF_FFF0, 32'd3, due + 1);
            e.tag = "b2b";
            sb.push_back(e);
            due2 = e.due;
        end
        wait_until(due2);

        // Randomized ops, with stray starts during busy periods.
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            issue(o, rand_operand(), rand_operand(), due);
            if (o <= 3'd3 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, due - edge_cnt - 1);
                repeat (j) @(negedge clk);
                start = 1'b1; op = 3'($urandom); A = $urandom; B = $urandom;
                @(negedge clk);
                start = 1'b0;
            end
            wait_until(due);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the MIPS datapath, sitting directly downstream of the general register file. It takes the rs/rt read data (`RD1`/`RD2`) of MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions. It holds the HI/LO architectural registers, emulates multi-cycle arithmetic latency with a busy counter, and drives `busy` so the hazard unit can stall MFHI/MFLO and further MD instructions.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe, sampled at the rising edge.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- `A`  in  32  rs operand, taken from the register file's `RD1`.
- `B`  in  32  rt operand, taken from the register file's `RD2`.
- `PC`  in  32  PC of the issuing instruction; used only for the trace.
- `busy`  out  1  registered; high while an arithmetic op is in flight.
- `HI`  out  32  HI register (MFHI source).
- `LO`  out  32  LO register (MFLO source).

## Operation
- States: IDLE and BUSY. The down-counter is 4 bits wide.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch `A`, `B`, `op` and the issuing `PC`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to BUSY.
- IDLE, `start`=1, op MTHI/MTLO: write `A` to HI or LO at that edge. No busy is raised.
- IDLE, `start`=1, op 6/7: ignored.
- BUSY: the counter decrements each edge. On the edge where the counter equals 1:
  - commit the result to HI/LO;
  - clear `busy`;
  - return to IDLE.
- Arithmetic is computed only from the latched operands:
  - MULT: signed 32×32→64. HI = bits 63:32, LO = bits 31:0.
  - MULTU: the same, unsigned.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (latched `B`=0): the full busy period still elapses, then HI and LO are left unchanged.
- `start` while BUSY (any op, including MTHI/MTLO) is ignored. Upstream must stall on `start | busy`; this block does not queue.
- Reset asserted at any time, including mid-operation:
  - HI=0, LO=0, `busy`=0, counter=0, state IDLE;
  - any in-flight operation is aborted with no commit.

## Timing
- Reset values: `busy`=0, `HI`=0x00000000, `LO`=0x00000000.
- Arithmetic op sampled at edge k:
  - `busy` is high from after edge k through edge k+N, where N is the op's cycle count.
  - New HI/LO are visible after edge k+N, in the same cycle `busy` falls.
- Back-to-back: a new `start` sampled at edge k+N (the commit edge) is ignored. The earliest accepted issue is at edge k+N+1.
- MTHI/MTLO: 1-cycle latency. The value is visible after the sampling edge.
- `HI`/`LO` are direct register outputs. There is no combinational path from `A`/`B` to any output.

## Configuration
- `MD_UNIT_TRACE_EN` defined:
  - every HI/LO write prints "@%h: HI <= %h" and/or "@%h: LO <= %h";
  - the printed PC is the latched PC for arithmetic ops and the live `PC` for MTHI/MTLO;
  - a divide by zero prints nothing.
- Not defined: no `$display` calls. `PC` is unused and logic behaviour is identical.

## Structure
- Shared package `md_pkg` holds:
  - the `op` encodings (MD_MULT…MD_MTLO);
  - the default latency constants;
  - the state enum (IDLE, BUSY).
- One sub-module, `md_counter`: a loadable 4-bit down-counter with a `done` pulse at count 1. The arithmetic stays in `md_unit`.

## Test plan
- MULT, A=3, B=0xFFFFFFFE (−2), start at edge 0 -> `busy` high for exactly 5 cycles; after edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (−7), B=2 -> `busy` for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 afterwards -> 10 busy cycles, HI/LO unchanged.
- MTHI A=0x12345678 during a MULT's busy period -> ignored; after the commit, MTHI A=0x12345678 -> HI=0x12345678 one edge later, `busy` never rises.
- DIV in flight, `reset` pulsed low at busy cycle 4 -> immediately `busy`=0, HI=LO=0; after release, no late commit occurs.
- Second MULT `start` held at the commit edge -> not accepted; accepted one edge later with a fresh 5-cycle busy.
